// File: rtl/ecc_nibble_host_pkg.sv
// ecc_if_pkg: shared widths, FSM states and error codes for the ECC nibble interface
package ecc_if_pkg;
    localparam int NIBBLE_W     = 4;
    localparam int WORD_W       = 32;
    localparam int SEND_NIBBLES = 8;
    localparam int RECV_NIBBLES = 16;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RECV} state_t;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_TIMEOUT    = 2'd1,
        ERR_READY_DROP = 2'd2
    } err_t;
endpackage

// File: rtl/ecc_nibble_host_if.sv
// ecc_nibble_host_if: operand/result bus plus the nibble link to the ECC core
interface ecc_nibble_host_if;
    import ecc_if_pkg::*;
    logic                start;
    logic [WORD_W-1:0]   a_word, prime_word, px_word, py_word, k_word;
    logic                busy;
    logic                valid;
    logic [NIBBLE_W-1:0] a, prime, Px, Py, k;
    logic                ready;
    logic [NIBBLE_W-1:0] kP;
    logic [WORD_W-1:0]   kpx, kpy;
    logic                done;
    logic [1:0]          err;

    modport master (
        output start, a_word, prime_word, px_word, py_word, k_word, ready, kP,
        input  busy, valid, a, prime, Px, Py, k, kpx, kpy, done, err
    );

    modport slave (
        input  start, a_word, prime_word, px_word, py_word, k_word, ready, kP,
        output busy, valid, a, prime, Px, Py, k, kpx, kpy, done, err
    );
endinterface

// File: rtl/ecc_nibble_host_piso.sv
// nibble_piso: 32-bit parallel-load register shifting left one nibble per cycle
module nibble_piso
    import ecc_if_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [WORD_W-1:0]   d,
    output logic [NIBBLE_W-1:0] q
);
    logic [WORD_W-1:0] r;

    // load takes priority so a new operand always overrides a shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r <= '0;
        else if (load) r <= d;
        else if (shift) r <= r << NIBBLE_W;
    end

    assign q = r[WORD_W-1 -: NIBBLE_W];
endmodule

// File: rtl/ecc_nibble_host.sv
// ecc_nibble_host: serializes five operands to the ECC core and deserializes kP
module ecc_nibble_host
    import ecc_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 65535
) (
    input logic               clk,
    input logic               rst,
    ecc_nibble_host_if.slave  h
);
    state_t                         state, state_n;
    logic [3:0]                     cnt, cnt_n;
    logic [15:0]                    tcnt, tcnt_n;
    logic [2*WORD_W-1:0]            res, res_n;
    logic [WORD_W-1:0]              kpx_r, kpy_r;
    logic                           done_r, done_n, upd, load, shift;
    err_t                           err_r, err_n;
    logic [4:0][WORD_W-1:0]         words;
    logic [4:0][NIBBLE_W-1:0]       nib;

    assign words = {h.a_word, h.prime_word, h.px_word, h.py_word, h.k_word};

    genvar g;
    for (g = 0; g < 5; g++) begin : g_piso
        nibble_piso u_piso (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .shift (shift),
            .d     (words[g]),
            .q     (nib[g])
        );
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // next state, counters, result shifting and completion/error decisions
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tcnt_n  = tcnt;
        res_n   = res;
        done_n  = 1'b0;
        err_n   = err_r;
        upd     = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state)
            IDLE: if (h.start) begin
                load    = 1'b1;
                err_n   = ERR_OK;
                cnt_n   = '0;
                state_n = SEND;
            end
            SEND: begin
                shift = 1'b1;
                cnt_n = cnt + 4'd1;
                if (cnt == 4'(SEND_NIBBLES - 1)) begin
                    cnt_n   = '0;
                    tcnt_n  = '0;
                    state_n = WAIT;
                end
            end
            WAIT: if (h.ready) begin
                res_n   = {res[2*WORD_W-NIBBLE_W-1:0], h.kP};
                cnt_n   = 4'd1;
                state_n = RECV;
            end else if (32'(tcnt) >= TIMEOUT) begin
                err_n   = ERR_TIMEOUT;
                done_n  = 1'b1;
                tcnt_n  = '0;
                state_n = IDLE;
            end else begin
                tcnt_n = tcnt + 16'd1;
            end
            RECV: if (!h.ready) begin
                err_n   = ERR_READY_DROP;
                done_n  = 1'b1;
                cnt_n   = '0;
                state_n = IDLE;
            end else begin
                res_n = {res[2*WORD_W-NIBBLE_W-1:0], h.kP};
                cnt_n = cnt + 4'd1;
                if (cnt == 4'(RECV_NIBBLES - 1)) begin
                    upd     = 1'b1;
                    done_n  = 1'b1;
                    err_n   = ERR_OK;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // datapath registers; results only land on a complete, error-free receive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tcnt   <= '0;
            res    <= '0;
            done_r <= 1'b0;
            err_r  <= ERR_OK;
            kpx_r  <= '0;
            kpy_r  <= '0;
        end else begin
            cnt    <= cnt_n;
            tcnt   <= tcnt_n;
            res    <= res_n;
            done_r <= done_n;
            err_r  <= err_n;
            if (upd) begin
                kpx_r <= res_n[2*WORD_W-1:WORD_W];
                kpy_r <= res_n[WORD_W-1:0];
            end
        end
    end

    assign h.busy  = state != IDLE;
    assign h.valid = state == SEND;
    assign h.a     = h.valid ? nib[4] : '0;
    assign h.prime = h.valid ? nib[3] : '0;
    assign h.Px    = h.valid ? nib[2] : '0;
    assign h.Py    = h.valid ? nib[1] : '0;
    assign h.k     = h.valid ? nib[0] : '0;
    assign h.kpx   = kpx_r;
    assign h.kpy   = kpy_r;
    assign h.done  = done_r;
    assign h.err   = err_r;
endmodule

// File: doc/ecc_nibble_host.md
# ecc_nibble_host

Host-side endpoint of the ECC core's 4-bit nibble interface. Accepts five 32-bit operands (a, prime, Px, Py, k) through a start/busy handshake and serializes them MSB-nibble-first over 8 cycles with `valid`. It then waits for the core's `ready` and deserializes the 16-nibble `kP` stream into the 32-bit result words kPx and kPy. It sits between the system bus/testbench and the ECC top, acting as transmitter for the core's input receiver and receiver for the core's output transmitter.

## Interface
- `TIMEOUT`, 65535: maximum cycles spent in WAIT before the block aborts with an error.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a transaction; sampled only in IDLE.
- `a_word`, `prime_word`, `px_word`, `py_word`, `k_word` in 32 each: operands, captured on an accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `valid` out 1: high for exactly 8 consecutive cycles per transaction.
- `a`, `prime`, `Px`, `Py`, `k` out 4 each: current nibble of each operand; 0 when `valid`=0.
- `ready` in 1: core output strobe; high for 16 consecutive cycles while `kP` carries the result.
- `kP` in 4: result nibble stream.
- `kpx`, `kpy` out 32 each: last received result; updated only on a successful `done`.
- `done` out 1: one-cycle pulse at the end of every transaction, success or error.
- `err` out 2: 0 = ok, 1 = timeout, 2 = `ready` dropped early; valid while `done`=1 and held until the next accepted `start`.

## Operation
- FSM states: IDLE, SEND, WAIT, RECV.
- **IDLE**
  - `start`=1 captures all five words into shift registers and clears `err`.
  - Clears the nibble counter and moves to SEND.
- **SEND**
  - `valid`=1. Each output nibble is the top 4 bits of its shift register; registers shift left by 4 each cycle.
  - After 8 cycles (counter 0..7), moves to WAIT with the counter cleared.
- **WAIT**
  - `ready`=1: samples `kP` as nibble 0 in that same cycle and moves to RECV with counter=1.
  - Counter reaching `TIMEOUT` with no `ready`: `err`=1, pulse `done`, return to IDLE.
- **RECV**
  - Samples `kP` every cycle while `ready`=1, forming result = (result<<4)|kP.
  - Nibbles 0..7 form kpx, MSB first; nibbles 8..15 form kpy, MSB first.
  - After nibble 15: load `kpx`/`kpy`, pulse `done` with `err`=0, go to IDLE.
  - `ready`=0 before nibble 15: `err`=2, pulse `done`, discard the partial result, go to IDLE. `kpx`/`kpy` are unchanged.
- `start` outside IDLE is ignored; no queuing.
- `ready`=1 during SEND is ignored. It is not treated as a result.
- Width rules:
  - Nibble counter is 4 bits and is reused across SEND and RECV.
  - Timeout counter is 16 bits; comparison is `>= TIMEOUT`.
  - `TIMEOUT`=0 means timeout on the first WAIT cycle unless `ready` is already high.

## Timing
- Reset values: state IDLE; `busy`, `valid`, `done` = 0; all nibble outputs 0; `kpx`, `kpy` = 0; `err` = 0; all counters 0.
- `start` accepted at edge T:
  - `busy` and `valid` are high from T+1.
  - Operand nibble i is presented in cycle T+1+i (i = 0..7), i.e. word[31-4i:28-4i].
  - `valid` falls at T+9.
- Result path:
  - If `ready` is first seen at edge R, nibble j is sampled at edge R+j.
  - `done`, `kpx`, and `kpy` are visible at R+16; `busy` is low at R+16.
- Back-to-back: `start` asserted while `done`=1 is accepted at the next edge, so the minimum transaction gap is 1 cycle.
- All outputs are registered; there is no combinational path from any input to any output.
- Asynchronous `rst` during any state returns the block to reset values immediately.
  - A partially sent operand is abandoned.
  - The core must be reset alongside this block.

## Structure
- Shared package `ecc_if_pkg` holds:
  - `NIBBLE_W`=4, `WORD_W`=32, `SEND_NIBBLES`=8, `RECV_NIBBLES`=16.
  - The FSM state enum.
  - Error codes `ERR_OK`, `ERR_TIMEOUT`, `ERR_READY_DROP`.
- One sub-module, `nibble_piso`: a 32-bit load/shift-left-by-4 register with a top-nibble output. It is instantiated five times, once per operand.
- Result deserializer, counters, and FSM stay in the top module.

## Test plan
- Basic send: start with a=0x12345678, prime=0x89ABCDEF, px=0x0F0F0F0F, py=0xF0F0F0F0, k=0xDEADBEEF -> `valid` high for exactly 8 cycles; a nibbles are 1,2,...,8; k nibbles are D,E,A,D,B,E,E,F.
- Basic receive: after SEND, drive `ready` for 16 cycles with kP nibbles 0xCAFEBABE then 0x01234567 -> `done` pulse with kpx=0xCAFEBABE, kpy=0x01234567, err=0, 16 cycles after the first `ready`.
- Timeout: `TIMEOUT`=20 and `ready` never asserted -> `done` with err=1 exactly 20 cycles into WAIT; kpx/kpy keep their previous values.
- Early drop: `ready` high for 5 cycles, then low -> `done` with err=2 on the cycle after the drop; kpx/kpy unchanged.
- Ignored start and back-to-back:
  - `start` pulsed during SEND/RECV -> no effect.
  - `start` held high through `done` -> the second transaction begins with `valid` at the cycle after `done`.
- Reset mid-RECV: assert `rst` after 10 nibbles -> all outputs return to 0 immediately; a following transaction completes normally.
